// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback with a ready handshake.
// Optional MC_CTRL_ILLEGAL_TRAP_EN adds an illegal output and a sticky TRAP state for unknown op/funct.
module multicycle_controller #(
  parameter int unsigned ALUCTRL_W = 3,
  parameter int unsigned OP_W      = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OP_W-1:0]      op,
  input  logic [OP_W-1:0]      funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 memwrite,
  output logic                 iord,
  output logic                 irwrite,
  output logic                 pcen,
  output logic [1:0]           pcsrc,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic                 zeroextend,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic [ALUCTRL_W-1:0] alucontrol
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                 illegal
`endif
);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_IMMEX,
    S_IMMWB,
    S_JUMP
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    ,
    S_TRAP
`endif
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] funct_alu;
  logic       funct_known;
  logic [2:0] alu3;
  logic       illegal_d;

  always_comb begin
    funct_alu   = ALU_ADD;
    funct_known = 1'b1;
    case (funct)
      OP_W'(6'b100000): funct_alu = ALU_ADD;
      OP_W'(6'b100010): funct_alu = ALU_SUB;
      OP_W'(6'b100100): funct_alu = ALU_AND;
      OP_W'(6'b100101): funct_alu = ALU_OR;
      OP_W'(6'b101010): funct_alu = ALU_SLT;
      default:          funct_known = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (op == OP_LW || op == OP_SW)                       state_d = S_MEMADR;
        else if (op == OP_RTYPE)                              state_d = S_EXECUTE;
        else if (op == OP_BEQ || op == OP_BNE)                state_d = S_BRANCH;
        else if (op == OP_ADDI || op == OP_ANDI || op == OP_ORI) state_d = S_IMMEX;
        else if (op == OP_J)                                  state_d = S_JUMP;
        else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXECUTE: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        state_d = funct_known ? S_ALUWB : S_TRAP;
`else
        state_d = S_ALUWB;
`endif
      end
      S_IMMEX:  state_d = S_IMMWB;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_TRAP:   state_d = S_TRAP;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Outputs are a combinational decode of state_q so that reset forces them
  // inactive in the same cycle and pcen/irwrite can follow mem_ready/zero.
  always_comb begin
    mem_req    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcen       = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    zeroextend = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alu3       = ALU_ADD;
    illegal_d  = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          alusrcb = 2'b01;
          irwrite = mem_ready;
          pcen    = mem_ready;
        end
        S_DECODE: alusrcb = 2'b11;
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
        end
        S_MEMWR: begin
          mem_req  = 1'b1;
          memwrite = 1'b1;
          iord     = 1'b1;
        end
        S_EXECUTE: begin
          alusrca = 1'b1;
          alu3    = funct_alu;
        end
        S_ALUWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        S_BRANCH: begin
          alusrca = 1'b1;
          alu3    = ALU_SUB;
          pcsrc   = 2'b01;
          pcen    = (op == OP_BEQ && zero) || (op == OP_BNE && !zero);
        end
        S_IMMEX: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          zeroextend = (op == OP_ANDI) || (op == OP_ORI);
          if (op == OP_ANDI)     alu3 = ALU_AND;
          else if (op == OP_ORI) alu3 = ALU_OR;
          else                   alu3 = ALU_ADD;
        end
        S_IMMWB: begin
          regwrite   = 1'b1;
          zeroextend = (op == OP_ANDI) || (op == OP_ORI);
        end
        S_JUMP: begin
          pcsrc = 2'b10;
          pcen  = 1'b1;
        end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        S_TRAP: illegal_d = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign alucontrol = ALUCTRL_W'(alu3);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal = illegal_d;
`else
  logic unused_ok;
  assign unused_ok = illegal_d ^ funct_known;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus pushes per-cycle expected outputs, a monitor compares.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, memwrite, iord, irwrite, pcen, alusrca, zeroextend, regdst, memtoreg, regwrite;
  logic [1:0] pcsrc, alusrcb;
  logic [2:0] alucontrol;
  logic       illegal_w;

  multicycle_controller #(.ALUCTRL_W(3), .OP_W(6)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite), .pcen(pcen),
    .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb), .zeroextend(zeroextend),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alucontrol(alucontrol)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , .illegal(illegal_w)
`endif
  );
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal_w = 1'b0;
`endif

  always #5 clk = ~clk;

  // {illegal, mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb, zeroext, regdst, memtoreg, regwrite, alu}
  localparam logic [17:0] RST   = {1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b0, 3'b010};
  localparam logic [17:0] FW    = {1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0, 2'b01, 1'b0,1'b0,1'b0,1'b0, 3'b010};
  localparam logic [17:0] FG    = {1'b0, 1'b1,1'b0,1'b0,1'b1,1'b1, 2'b00, 1'b0, 2'b01, 1'b0,1'b0,1'b0,1'b0, 3'b010};
  localparam logic [17:0] DEC   = {1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0, 2'b11, 1'b0,1'b0,1'b0,1'b0, 3'b010};
  localparam logic [17:0] MADR  = {1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b1, 2'b10, 1'b0,1'b0,1'b0,1'b0, 3'b010};
  localparam logic [17:0] MRD   = {1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0, 2'b00, 1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b0, 3'b010};
  localparam logic [17:0] MWB   = {1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0, 2'b00, 1'b0,1'b0,1'b1,1'b1, 3'b010};
  localparam logic [17:0] MWR   = {1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0, 2'b00, 1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b0, 3'b010};
  localparam logic [17:0] EXSUB = {1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b1, 2'b00, 1'b0,1'b0,1'b0,1'b0, 3'b110};
  localparam logic [17:0] AWB   = {1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0, 2'b00, 1'b0,1'b1,1'b0,1'b1, 3'b010};
  localparam logic [17:0] BRT   = {1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b01, 1'b1, 2'b00, 1'b0,1'b0,1'b0,1'b0, 3'b110};
  localparam logic [17:0] BRN   = {1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01, 1'b1, 2'b00, 1'b0,1'b0,1'b0,1'b0, 3'b110};
  localparam logic [17:0] IXORI = {1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b1, 2'b10, 1'b1,1'b0,1'b0,1'b0, 3'b001};
  localparam logic [17:0] IWORI = {1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0, 2'b00, 1'b1,1'b0,1'b0,1'b1, 3'b010};
  localparam logic [17:0] JMP   = {1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10, 1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b0, 3'b010};
  localparam logic [17:0] TRAP  = {1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b0, 3'b010};

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, ORI = 6'b001101, JJ = 6'b000010, BAD = 6'b111111;
  localparam logic [5:0] FSUB = 6'b100010;

  logic [17:0] eq[$];
  string       nq[$];
  int          total = 0;
  int          bad = 0;
  int          wr_cnt = 0;
  logic        chk_wr = 1'b0;
  logic        wr_done = 1'b0;
  logic [17:0] act;

  assign act = {illegal_w, mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
                zeroextend, regdst, memtoreg, regwrite, alucontrol};

  always @(negedge clk) begin
    logic [17:0] e;
    string       n;
    if (eq.size() > 0) begin
      e = eq.pop_front();
      n = nq.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got %b expected %b", n, act, e);
      end
    end
    if (memwrite === 1'b1) wr_cnt++;
    if (chk_wr && !wr_done) begin
      wr_done <= 1'b1;
      total++;
      if (wr_cnt != 2) begin
        bad++;
        $display("FAIL memwrite_count: got %0d expected 2", wr_cnt);
      end
    end
  end

  task automatic cyc(input logic r, input logic [5:0] o_, input logic [5:0] f, input logic z,
                     input logic mr, input logic [17:0] e, input string n);
    reset = r; op = o_; funct = f; zero = z; mem_ready = mr;
    eq.push_back(e);
    nq.push_back(n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    cyc(1, LW, 0, 0, 1, RST, "reset1");
    cyc(1, LW, 0, 0, 1, RST, "reset2");
    // lw, zero wait states: 5 cycles
    cyc(0, LW, 0, 0, 1, FG,   "lw_fetch");
    cyc(0, LW, 0, 0, 1, DEC,  "lw_decode");
    cyc(0, LW, 0, 0, 1, MADR, "lw_memadr");
    cyc(0, LW, 0, 0, 1, MRD,  "lw_memrd");
    cyc(0, LW, 0, 0, 0, MWB,  "lw_memwb");
    // R-type sub
    cyc(0, RT, FSUB, 0, 1, FG,    "r_fetch");
    cyc(0, RT, FSUB, 0, 0, DEC,   "r_decode");
    cyc(0, RT, FSUB, 0, 0, EXSUB, "r_execute_sub");
    cyc(0, RT, FSUB, 0, 0, AWB,   "r_aluwb");
    // branches
    cyc(0, BEQ, 0, 1, 1, FG,  "beq_fetch");
    cyc(0, BEQ, 0, 1, 1, DEC, "beq_decode");
    cyc(0, BEQ, 0, 1, 0, BRT, "beq_z1_taken");
    cyc(0, BNE, 0, 1, 1, FG,  "bne1_fetch");
    cyc(0, BNE, 0, 1, 0, DEC, "bne1_decode");
    cyc(0, BNE, 0, 1, 1, BRN, "bne_z1_not_taken");
    cyc(0, BNE, 0, 0, 1, FG,  "bne0_fetch");
    cyc(0, BNE, 0, 0, 0, DEC, "bne0_decode");
    cyc(0, BNE, 0, 0, 0, BRT, "bne_z0_taken");
    // fetch wait states, then j
    cyc(0, JJ, 0, 0, 0, FW,  "fetch_wait1");
    cyc(0, JJ, 0, 0, 0, FW,  "fetch_wait2");
    cyc(0, JJ, 0, 0, 0, FW,  "fetch_wait3");
    cyc(0, JJ, 0, 0, 1, FG,  "fetch_ready");
    cyc(0, JJ, 0, 0, 0, DEC, "j_decode");
    cyc(0, JJ, 0, 0, 0, JMP, "j_jump");
    // sw with wait states, aborted by reset
    cyc(0, SW, 0, 0, 1, FG,   "sw_fetch");
    cyc(0, SW, 0, 0, 1, DEC,  "sw_decode");
    cyc(0, SW, 0, 0, 1, MADR, "sw_memadr");
    cyc(0, SW, 0, 0, 0, MWR,  "sw_wait1");
    cyc(0, SW, 0, 0, 0, MWR,  "sw_wait2");
    cyc(1, SW, 0, 0, 1, RST,  "sw_reset");
    // ori
    cyc(0, ORI, 0, 0, 1, FG,    "ori_fetch");
    cyc(0, ORI, 0, 0, 0, DEC,   "ori_decode");
    cyc(0, ORI, 0, 0, 0, IXORI, "ori_immex");
    cyc(0, ORI, 0, 0, 0, IWORI, "ori_immwb");
    // unknown op
    cyc(0, BAD, 0, 0, 1, FG,  "bad_fetch");
    cyc(0, BAD, 0, 0, 0, DEC, "bad_decode");
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    cyc(0, BAD, 0, 0, 1, TRAP, "trap1");
    cyc(0, RT,  0, 1, 1, TRAP, "trap2");
    cyc(0, LW,  0, 0, 0, TRAP, "trap3");
    cyc(1, LW,  0, 0, 0, RST,  "trap_reset");
    cyc(0, LW,  0, 0, 0, FW,   "after_trap_fetch");
`else
    cyc(0, BAD, 0, 0, 0, FW, "bad_nop_fetch");
    cyc(0, BAD, 0, 0, 1, FG, "bad_nop_fetch_go");
    cyc(0, BAD, 0, 0, 0, DEC, "bad_nop_decode2");
    cyc(0, BAD, 0, 0, 0, FW, "bad_nop_fetch2");
`endif
    cyc(1, RT, 0, 0, 0, RST, "final_reset");
    for (int i = 0; i < 20 && eq.size() > 0; i++) @(posedge clk);
    if (eq.size() > 0) begin
      $display("FAIL drain_timeout: got %0d pending expected 0", eq.size());
      $fatal(1, "scoreboard did not drain");
    end
    chk_wr = 1'b1;
    @(posedge clk);
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
